// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the audio soft-mute stage
// Contents: mute_state_t ramp FSM encoding, gain_max() unity-gain helper.
package audio_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        UNMUTED   = 2'd2,
        RAMP_DOWN = 2'd3
    } mute_state_t;

    // Unity gain for a gain word with gain_bits fraction bits.
    function automatic int gain_max(input int gain_bits);
        return 1 << gain_bits;
    endfunction

endpackage

// File: rtl/audio_gain_channel.sv
// rtl/audio_gain_channel.sv - two-stage gain multiply/shift pipeline for one audio channel
// Ports:
//   clk_audio  in   sample clock
//   reset      in   synchronous, active-high; clears both stages
//   sample     in   signed input sample
//   gain       in   unsigned gain, 0..2^GAIN_BITS, paired with sample this cycle
//   scaled     out  (sample * gain) >>> GAIN_BITS, two cycles after sample
module audio_gain_channel #(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int GAIN_BITS       = 8
) (
    input  logic                              clk_audio,
    input  logic                              reset,
    input  logic signed [AUDIO_BIT_WIDTH-1:0] sample,
    input  logic        [GAIN_BITS:0]         gain,
    output logic signed [AUDIO_BIT_WIDTH-1:0] scaled
);

    // Product width: the gain never exceeds unity, so the magnitude of the
    // product is bounded by 2^(AUDIO_BIT_WIDTH-1+GAIN_BITS) and fits here.
    localparam int PW = AUDIO_BIT_WIDTH + GAIN_BITS + 1;

    logic signed [AUDIO_BIT_WIDTH-1:0] s1_sample;
    logic        [GAIN_BITS:0]         s1_gain;
    logic signed [PW-1:0]              sample_ext;
    logic signed [PW-1:0]              gain_ext;
    logic signed [PW-1:0]              product;

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            s1_sample <= '0;
            s1_gain   <= '0;
        end else begin
            s1_sample <= sample;
            s1_gain   <= gain;
        end
    end

    always_comb begin
        sample_ext = PW'(s1_sample);
        gain_ext   = $signed(PW'({1'b0, s1_gain}));
        product    = sample_ext * gain_ext;
    end

    // Arithmetic shift floors toward -inf; at unity gain this is bit-exact.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            scaled <= '0;
        end else begin
            scaled <= AUDIO_BIT_WIDTH'(product >>> GAIN_BITS);
        end
    end

endmodule

// File: rtl/audio_soft_mute.sv
// rtl/audio_soft_mute.sv - soft mute/unmute gain ramp ahead of the HDMI packet picker
// Ports:
//   clk_audio          in   sample clock, one stereo sample per rising edge
//   reset              in   synchronous, active-high
//   mute               in   asynchronous mute request level (1 = mute)
//   in_sample_word     in   signed stereo samples, [0] = left, [1] = right
//   audio_sample_word  out  gain-scaled stereo samples, 2-cycle latency
//   muted              out  high while MUTED
//   ramping            out  high while RAMP_UP or RAMP_DOWN
//   gain               out  current gain, 0..2^GAIN_BITS
module audio_soft_mute
    import audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int GAIN_BITS       = 8,
    parameter int RAMP_STEP       = 1,
    parameter int START_MUTED     = 1
) (
    input  logic                              clk_audio,
    input  logic                              reset,
    input  logic                              mute,
    input  logic signed [AUDIO_BIT_WIDTH-1:0] in_sample_word    [1:0],
    output logic signed [AUDIO_BIT_WIDTH-1:0] audio_sample_word [1:0],
    output logic                              muted,
    output logic                              ramping,
    output logic        [GAIN_BITS:0]         gain
);

    // Gain arithmetic is done one bit wider than the gain word so that
    // g + RAMP_STEP cannot wrap before it is compared against unity.
    localparam int XW = GAIN_BITS + 2;
    localparam int GW = GAIN_BITS + 1;

    localparam logic [XW-1:0] GMAX = XW'(gain_max(GAIN_BITS));
    localparam logic [XW-1:0] STEP = XW'(RAMP_STEP);

    // A step of a full unity gain makes a single-cycle transition; the
    // intermediate ramp states are skipped so ramping never pulses.
    localparam bit HARD = (RAMP_STEP >= gain_max(GAIN_BITS));

    localparam logic        SYNC_INIT   = (START_MUTED != 0);
    localparam mute_state_t RESET_STATE = (START_MUTED != 0) ? MUTED : UNMUTED;
    localparam logic [GW-1:0] RESET_GAIN =
        (START_MUTED != 0) ? '0 : GW'(gain_max(GAIN_BITS));

    logic          mute_meta;
    logic          mute_s;
    mute_state_t   state;
    mute_state_t   state_next;
    logic [XW-1:0] g_w;
    logic [XW-1:0] g_up;
    logic [XW-1:0] g_up_sat;
    logic [XW-1:0] g_dn;
    logic [XW-1:0] g_next_w;
    logic [GW-1:0] gain_next;

    // Two-flop synchroniser for the asynchronous mute request.
    always_ff @(posedge clk_audio) begin
        if (reset) begin
            mute_meta <= SYNC_INIT;
            mute_s    <= SYNC_INIT;
        end else begin
            mute_meta <= mute;
            mute_s    <= mute_meta;
        end
    end

    always_ff @(posedge clk_audio) begin
        if (reset) begin
            state   <= RESET_STATE;
            gain    <= RESET_GAIN;
            muted   <= (RESET_STATE == MUTED);
            ramping <= 1'b0;
        end else begin
            state   <= state_next;
            gain    <= gain_next;
            muted   <= (state_next == MUTED);
            ramping <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
        end
    end

    always_comb begin
        g_w        = {1'b0, gain};
        g_up       = g_w + STEP;
        g_up_sat   = (g_up >= GMAX) ? GMAX : g_up;
        g_dn       = (g_w > STEP) ? (g_w - STEP) : '0;
        state_next = state;
        g_next_w   = g_w;

        case (state)
            MUTED: begin
                g_next_w = '0;
                if (!mute_s) begin
                    if (HARD) begin
                        state_next = UNMUTED;
                        g_next_w   = GMAX;
                    end else begin
                        state_next = RAMP_UP;
                        g_next_w   = STEP;
                    end
                end
            end
            RAMP_UP: begin
                if (mute_s) begin
                    // Reverse from the current gain rather than jumping.
                    state_next = RAMP_DOWN;
                    g_next_w   = g_dn;
                end else if (g_up >= GMAX) begin
                    state_next = UNMUTED;
                    g_next_w   = GMAX;
                end else begin
                    g_next_w   = g_up;
                end
            end
            UNMUTED: begin
                if (mute_s) begin
                    if (HARD) begin
                        state_next = MUTED;
                        g_next_w   = '0;
                    end else begin
                        state_next = RAMP_DOWN;
                        g_next_w   = GMAX - STEP;
                    end
                end
            end
            RAMP_DOWN: begin
                if (!mute_s) begin
                    state_next = RAMP_UP;
                    g_next_w   = g_up_sat;
                end else if (g_w <= STEP) begin
                    state_next = MUTED;
                    g_next_w   = '0;
                end else begin
                    g_next_w   = g_dn;
                end
            end
            default: begin
                state_next = RESET_STATE;
                g_next_w   = XW'(RESET_GAIN);
            end
        endcase

        gain_next = GW'(g_next_w);
    end

    // The registered gain is paired with the sample entering stage 1, so
    // the audio output trails the status outputs by the pipeline latency.
    audio_gain_channel #(
        .AUDIO_BIT_WIDTH (AUDIO_BIT_WIDTH),
        .GAIN_BITS       (GAIN_BITS)
    ) u_left (
        .clk_audio (clk_audio),
        .reset     (reset),
        .sample    (in_sample_word[0]),
        .gain      (gain),
        .scaled    (audio_sample_word[0])
    );

    audio_gain_channel #(
        .AUDIO_BIT_WIDTH (AUDIO_BIT_WIDTH),
        .GAIN_BITS       (GAIN_BITS)
    ) u_right (
        .clk_audio (clk_audio),
        .reset     (reset),
        .sample    (in_sample_word[1]),
        .gain      (gain),
        .scaled    (audio_sample_word[1])
    );

endmodule

// File: tb/tb_audio_soft_mute.sv
// tb/tb_audio_soft_mute.sv - directed self-checking bench for audio_soft_mute
module tb_audio_soft_mute;

    logic               clk_audio;
    logic               reset;
    logic               mute_a;
    logic               mute_h;
    logic signed [15:0] in_w  [1:0];
    logic signed [15:0] out_a [1:0];
    logic signed [15:0] out_h [1:0];
    logic               muted_a, ramping_a, muted_h, ramping_h;
    logic [4:0]         gain_a, gain_h;

    int n_asserts = 0;
    int n_fail    = 0;

    audio_soft_mute #(
        .AUDIO_BIT_WIDTH (16),
        .GAIN_BITS       (4),
        .RAMP_STEP       (1),
        .START_MUTED     (1)
    ) dut (
        .clk_audio         (clk_audio),
        .reset             (reset),
        .mute              (mute_a),
        .in_sample_word    (in_w),
        .audio_sample_word (out_a),
        .muted             (muted_a),
        .ramping           (ramping_a),
        .gain              (gain_a)
    );

    audio_soft_mute #(
        .AUDIO_BIT_WIDTH (16),
        .GAIN_BITS       (4),
        .RAMP_STEP       (16),
        .START_MUTED     (0)
    ) dut_hard (
        .clk_audio         (clk_audio),
        .reset             (reset),
        .mute              (mute_h),
        .in_sample_word    (in_w),
        .audio_sample_word (out_h),
        .muted             (muted_h),
        .ramping           (ramping_h),
        .gain              (gain_h)
    );

    initial clk_audio = 1'b0;
    always #5 clk_audio = ~clk_audio;

    task automatic step();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ramp-up gain n cycles after releasing mute from MUTED, step 1, unity 16.
    function automatic int up_gain(input int n);
        if (n < 3)       return 0;
        else if (n > 18) return 16;
        else             return n - 2;
    endfunction

    // Ramp-down gain n cycles after asserting mute from UNMUTED.
    function automatic int down_gain(input int n);
        if (n < 3)        return 16;
        else if (n > 18)  return 0;
        else              return 18 - n;
    endfunction

    int rev_gain [14] = '{0, 0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0};
    int hard_off [4]  = '{16, 16, 0, 0};
    int hard_on  [4]  = '{0, 0, 16, 16};

    initial begin
        // Reset and hold-muted behaviour
        reset  = 1'b1;
        mute_a = 1'b1;
        mute_h = 1'b0;
        in_w[0] = 16'sd1000;
        in_w[1] = -16'sd1000;
        step();
        step();
        reset = 1'b0;
        chk("rst_a_muted",   32'(muted_a), 1);
        chk("rst_a_ramping", 32'(ramping_a), 0);
        chk("rst_a_gain",    32'(gain_a), 0);
        chk("rst_a_out_l",   32'(out_a[0]), 0);
        chk("rst_h_muted",   32'(muted_h), 0);
        chk("rst_h_gain",    32'(gain_h), 16);
        chk("rst_h_ramping", 32'(ramping_h), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_out_l", 32'(out_a[0]), 0);
            chk("hold_out_r", 32'(out_a[1]), 0);
            chk("hold_muted", 32'(muted_a), 1);
            chk("hold_gain",  32'(gain_a), 0);
        end
        chk("h_pass_l", 32'(out_h[0]), 1000);
        chk("h_pass_r", 32'(out_h[1]), -1000);

        // Ramp up from mute release
        mute_a = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            step();
            chk("up_gain",    32'(gain_a), up_gain(n));
            chk("up_muted",   32'(muted_a), (n < 3) ? 1 : 0);
            chk("up_ramping", 32'(ramping_a), (n >= 3 && n < 18) ? 1 : 0);
            chk("up_out_l",   32'(out_a[0]), (1000 * up_gain(n - 2)) >>> 4);
            chk("up_out_r",   32'(out_a[1]), (-1000 * up_gain(n - 2)) >>> 4);
        end
        chk("up_out_l_62",   32'(out_a[0]), 1000);

        // Unity gain is bit-exact at full scale
        in_w[0] = -16'sd32768;
        in_w[1] = 16'sd32767;
        step();
        step();
        chk("unity_neg_fs", 32'(out_a[0]), -32768);
        chk("unity_pos_fs", 32'(out_a[1]), 32767);
        in_w[0] = 16'sd1000;
        in_w[1] = -16'sd1000;

        // Ramp down, with arithmetic probes at gain 8 and gain 1
        mute_a = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            step();
            chk("dn_gain", 32'(gain_a), down_gain(n));
            if (n == 10) begin
                in_w[0] = -16'sd1;
                in_w[1] = 16'sd16;
            end
            if (n == 11 || n == 18) begin
                in_w[0] = 16'sd1000;
                in_w[1] = -16'sd1000;
            end
            if (n == 12) begin
                chk("g8_neg1",  32'(out_a[0]), -1);
                chk("g8_16",    32'(out_a[1]), 8);
            end
            if (n == 17) begin
                in_w[0] = 16'sd32767;
                in_w[1] = -16'sd32768;
            end
            if (n == 18) chk("dn_muted", 32'(muted_a), 1);
            if (n == 19) begin
                chk("g1_pos_fs", 32'(out_a[0]), 2047);
                chk("g1_neg_fs", 32'(out_a[1]), -2048);
            end
        end

        // Reversal from RAMP_UP at gain 6
        mute_a = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            step();
            chk("rev_gain", 32'(gain_a), rev_gain[n - 1]);
            if (n == 6) mute_a = 1'b1;
            if (n == 9) chk("rev_ramping", 32'(ramping_a), 1);
            if (n == 13) chk("rev_not_muted", 32'(muted_a), 0);
        end
        chk("rev_muted", 32'(muted_a), 1);

        // Reset in the middle of a ramp
        mute_a = 1'b0;
        for (int n = 1; n <= 11; n++) step();
        chk("pre_rst_gain", 32'(gain_a), 9);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        mute_a = 1'b1;
        chk("mid_rst_gain",  32'(gain_a), 0);
        chk("mid_rst_muted", 32'(muted_a), 1);
        chk("mid_rst_out0",  32'(out_a[0]), 0);
        step();
        chk("mid_rst_out1", 32'(out_a[0]), 0);
        step();
        chk("mid_rst_out2", 32'(out_a[0]), 0);
        chk("mid_rst_h_gain", 32'(gain_h), 16);

        // Hard mute: one-cycle transitions, never ramping
        mute_h = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("hard_off_gain",    32'(gain_h), hard_off[n - 1]);
            chk("hard_off_muted",   32'(muted_h), (n >= 3) ? 1 : 0);
            chk("hard_off_ramping", 32'(ramping_h), 0);
        end
        mute_h = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("hard_on_gain",    32'(gain_h), hard_on[n - 1]);
            chk("hard_on_muted",   32'(muted_h), (n < 3) ? 1 : 0);
            chk("hard_on_ramping", 32'(ramping_h), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
